pcm_mm_rr_arbiter: RTL and testbench
====================================

Name: pcm_mm_rr_arbiter

Overview:
Parametrised N-channel successor to the fixed four-CPU PCM memory-mapped port. It arbitrates word read/write requests from NUM_CPU CPU channels onto a single Avalon-MM pcm_mem_mm master port using fair round-robin priority. It supports per-channel halt masking and a configurable fixed read latency. It sits between the CPU cores and the on-chip PCM memory inside the PCCM.

Parameters:
NUM_CPU, 4, number of requesting channels (2..16)
ADDR_W, 20, word address width
DATA_W, 16, data width; must be a multiple of 8
READ_LAT, 1, cycles from the issue cycle to valid pcm_mem_mm_readdata (1..8)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init  in  1  synchronous soft re-initialise; same effect as reset
cpu_req  in  NUM_CPU  per-channel request level
cpu_write  in  NUM_CPU  1 = write, 0 = read
cpu_halt  in  NUM_CPU  1 = channel not eligible for a new grant
cpu_addr  in  NUM_CPU*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
cpu_data_in  in  NUM_CPU*DATA_W  packed write data
cpu_ready  out  NUM_CPU  one-cycle completion pulse per channel
cpu_data_out  out  NUM_CPU*DATA_W  packed registered read data
pcm_mem_mm_address  out  ADDR_W  memory address
pcm_mem_mm_chipselect  out  1  access strobe
pcm_mem_mm_clken  out  1  memory clock enable
pcm_mem_mm_write  out  1  write strobe
pcm_mem_mm_writedata  out  DATA_W  write data
pcm_mem_mm_byteenable  out  DATA_W/8  byte enables
pcm_mem_mm_readdata  in  DATA_W  read data
busy  out  1  a transaction is in flight
grant_idx  out  $clog2(NUM_CPU)  index of the channel currently granted

Behaviour:
- Reset or init: FSM goes to IDLE, rr_ptr=0, grant_idx=0, busy=0, cpu_ready=0, cpu_data_out=0. All pcm_mem_mm outputs are 0. This takes effect mid-transaction with no completion pulse; the in-flight request is dropped. reset and init are equivalent and may be asserted simultaneously.
- Eligible set: cpu_req & ~cpu_halt.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the eligible set is nonzero, grant the first eligible channel scanning upward from rr_ptr, wrapping NUM_CPU-1 to 0.
  - Latch that channel's addr, data and write into internal registers; set grant_idx and busy=1; go to ISSUE.
  - Requests are sampled only in IDLE.
- ISSUE (exactly one cycle):
  - chipselect=1, clken=1, byteenable all ones.
  - address and writedata come from the latched registers; write = latched write.
  - Next state: write goes to RESP; read goes to WAIT with counter=READ_LAT.
- WAIT:
  - clken=1, chipselect=0; the counter decrements each cycle.
  - On the cycle the counter equals 1, capture readdata into slot grant_idx of cpu_data_out, then go to RESP.
  - WAIT therefore lasts READ_LAT cycles.
- RESP (one cycle):
  - cpu_ready[grant_idx]=1; all other ready bits are 0.
  - rr_ptr = (grant_idx+1) mod NUM_CPU, with wrap for non-power-of-2 NUM_CPU.
  - busy stays 1 through RESP and goes to 0 on entry to IDLE.
- Latency from the IDLE grant cycle T:
  - write: ready at T+2.
  - read: ready at T+2+READ_LAT.
  - No back-to-back bus cycles; minimum gap is 1 IDLE cycle.
- Requester rule: deassert cpu_req at the edge where its cpu_ready is seen. A req still high in the following IDLE is a new request.
- Data hold: cpu_data_out slots hold their value until the next read completion on that channel. Writes never modify them.
- cpu_halt changes mid-transaction do not abort the in-flight access. They affect only the next IDLE arbitration.
- Latched address/data are immune to cpu_addr or cpu_data_in changes after the grant.
- cpu_ready is never asserted for more than one channel in any cycle.

Test Plan:
- Reset then single read: NUM_CPU=4, READ_LAT=1. cpu_req=0001, cpu_addr0=20'h00ABC, readdata=16'h1234 held.
  -> address=20'h00ABC with chipselect=1 at T+1; cpu_ready[0] at T+3; cpu_data_out slot0=16'h1234.
- Write on channel 2: addr 20'hFFFFF, data 16'h0FF0.
  -> at T+1: write=1, writedata=16'h0FF0, byteenable=2'b11; cpu_ready[2] at T+2; cpu_data_out unchanged.
- Round-robin fairness: cpu_req=1111 held, each req dropped at its ready and re-raised the next cycle.
  -> grant order 0,1,2,3,0,1; no channel granted twice before all others are served.
- Halt masking: cpu_req=0011, cpu_halt=0001.
  -> only channel 1 is served. Release halt -> channel 0 is served next.
- Latency parameter: READ_LAT=3, read on channel 3.
  -> ready at T+5; readdata changing before T+4 is ignored; the value at T+4 is captured.
- Abort: assert init (then, separately, reset) in the WAIT cycle.
  -> no cpu_ready pulse; next cycle busy=0, all outputs 0, rr_ptr=0; the next request on channel 1 is granted normally.

Source files
------------

// File: rtl/pcm_mm_rr_arbiter.sv
// pcm_mm_rr_arbiter: round-robin arbiter of NUM_CPU word channels onto one Avalon-MM PCM port
module pcm_mm_rr_arbiter #(
  parameter int NUM_CPU  = 4,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [NUM_CPU-1:0]         cpu_req,
  input  logic [NUM_CPU-1:0]         cpu_write,
  input  logic [NUM_CPU-1:0]         cpu_halt,
  input  logic [NUM_CPU*ADDR_W-1:0]  cpu_addr,
  input  logic [NUM_CPU*DATA_W-1:0]  cpu_data_in,
  output logic [NUM_CPU-1:0]         cpu_ready,
  output logic [NUM_CPU*DATA_W-1:0]  cpu_data_out,
  output logic [ADDR_W-1:0]          pcm_mem_mm_address,
  output logic                       pcm_mem_mm_chipselect,
  output logic                       pcm_mem_mm_clken,
  output logic                       pcm_mem_mm_write,
  output logic [DATA_W-1:0]          pcm_mem_mm_writedata,
  output logic [DATA_W/8-1:0]        pcm_mem_mm_byteenable,
  input  logic [DATA_W-1:0]          pcm_mem_mm_readdata,
  output logic                       busy,
  output logic [$clog2(NUM_CPU)-1:0] grant_idx
);
  localparam int IW = $clog2(NUM_CPU);
  localparam int CW = $clog2(READ_LAT + 1);
  localparam logic [IW:0] NC = (IW+1)'(NUM_CPU);
  localparam logic [IW-1:0] LAST = IW'(NUM_CPU - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic clr;
  logic [NUM_CPU-1:0] elig;
  logic [IW-1:0] rr_q, grant_q, pick;
  logic [IW:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic wr_q;
  logic [CW-1:0] cnt_q;
  logic [NUM_CPU*DATA_W-1:0] rdata_q;
  assign clr = reset | init;
  assign elig = cpu_req & ~cpu_halt;
  assign grant_idx = grant_q;
  assign cpu_data_out = rdata_q;
  // State register; reset and init both drop any in-flight access
  always_ff @(posedge clk)
    state_q <= clr ? IDLE : state_d;
  // Next state: writes skip WAIT, reads spend READ_LAT cycles there
  always_comb
    state_d = state_q == IDLE  ? (|elig ? ISSUE : IDLE) :
              state_q == ISSUE ? (wr_q ? RESP : WAIT) :
              state_q == WAIT  ? (cnt_q == CW'(1) ? RESP : WAIT) : IDLE;
  // First eligible channel at or above rr_q; the downward scan lets the nearest one win
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + (IW+1)'(i);
      idx = idx >= NC ? idx - NC : idx;
      if (elig[idx[IW-1:0]]) pick = idx[IW-1:0];
    end
  end
  // Request latch, read-latency counter, read data capture and pointer advance
  always_ff @(posedge clk)
    if (clr) begin
      rr_q <= '0;
      grant_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && |elig) begin
        grant_q <= pick;
        addr_q <= cpu_addr[pick*ADDR_W +: ADDR_W];
        data_q <= cpu_data_in[pick*DATA_W +: DATA_W];
        wr_q <= cpu_write[pick];
      end
      if (state_q == ISSUE) cnt_q <= CW'(READ_LAT);
      if (state_q == WAIT) cnt_q <= cnt_q - 1'b1;
      if (state_q == WAIT && cnt_q == CW'(1)) rdata_q[grant_q*DATA_W +: DATA_W] <= pcm_mem_mm_readdata;
      if (state_q == RESP) rr_q <= grant_q == LAST ? '0 : grant_q + 1'b1;
    end
  // Bus strobes and completion pulse decoded from the state
  always_comb begin
    pcm_mem_mm_chipselect = state_q == ISSUE;
    pcm_mem_mm_clken = state_q == ISSUE || state_q == WAIT;
    pcm_mem_mm_write = state_q == ISSUE && wr_q;
    pcm_mem_mm_address = state_q == ISSUE ? addr_q : '0;
    pcm_mem_mm_writedata = state_q == ISSUE ? data_q : '0;
    pcm_mem_mm_byteenable = {(DATA_W/8){state_q == ISSUE}};
    cpu_ready = state_q == RESP ? NUM_CPU'(1) << grant_q : '0;
    busy = state_q != IDLE;
  end
endmodule

// File: tb/tb_pcm_mm_rr_arbiter.sv
// tb_pcm_mm_rr_arbiter: scoreboard bench for the round-robin PCM arbiter
module tb_pcm_mm_rr_arbiter;
  localparam int N = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  typedef struct {int ch; bit w; logic [AW-1:0] a; logic [DW-1:0] r;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, init;
  logic [N-1:0] req, wr, halt;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] din;
  logic [DW-1:0] rdata;
  logic [N-1:0] ready, ready3;
  logic [N*DW-1:0] dout, dout3;
  logic [AW-1:0] address, address3;
  logic cs, cs3, clken, clken3, mwrite, mwrite3, busy, busy3;
  logic [DW-1:0] wdata, wdata3;
  logic [1:0] be, be3, gidx, gidx3;
  exp_t sb[$];
  exp_t e;
  logic [N*DW-1:0] mdout;
  int n_cmp = 0, n_bad = 0;
  int obs_iss, obs_lat;
  logic [N-1:0] obs_rdy;
  logic [AW-1:0] obs_addr;
  logic obs_w;
  logic [DW-1:0] obs_wd;
  logic [1:0] obs_be, obs_g;

  pcm_mm_rr_arbiter #(.NUM_CPU(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset), .init(init), .cpu_req(req), .cpu_write(wr), .cpu_halt(halt),
    .cpu_addr(addr), .cpu_data_in(din), .cpu_ready(ready), .cpu_data_out(dout),
    .pcm_mem_mm_address(address), .pcm_mem_mm_chipselect(cs), .pcm_mem_mm_clken(clken),
    .pcm_mem_mm_write(mwrite), .pcm_mem_mm_writedata(wdata), .pcm_mem_mm_byteenable(be),
    .pcm_mem_mm_readdata(rdata), .busy(busy), .grant_idx(gidx));

  pcm_mm_rr_arbiter #(.NUM_CPU(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .init(init), .cpu_req(req), .cpu_write(wr), .cpu_halt(halt),
    .cpu_addr(addr), .cpu_data_in(din), .cpu_ready(ready3), .cpu_data_out(dout3),
    .pcm_mem_mm_address(address3), .pcm_mem_mm_chipselect(cs3), .pcm_mem_mm_clken(clken3),
    .pcm_mem_mm_write(mwrite3), .pcm_mem_mm_writedata(wdata3), .pcm_mem_mm_byteenable(be3),
    .pcm_mem_mm_readdata(rdata), .busy(busy3), .grant_idx(gidx3));

  // Called in the grant cycle; records the issue snapshot and the completion, drops req on ready
  task automatic wait_done(input bit use3, input bit scr, input int cap_k, input logic [DW-1:0] good);
    obs_iss = -1;
    obs_lat = -1;
    obs_rdy = '0;
    rdata = ~good;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rdata = (k == cap_k) ? good : ~good;
      if (scr && k == 1) begin
        addr = ~addr;
        din = ~din;
      end
      if (use3 ? cs3 : cs) begin
        obs_iss = k;
        obs_addr = use3 ? address3 : address;
        obs_w = use3 ? mwrite3 : mwrite;
        obs_wd = use3 ? wdata3 : wdata;
        obs_be = use3 ? be3 : be;
        obs_g = use3 ? gidx3 : gidx;
      end
      if ((use3 ? ready3 : ready) != '0) begin
        obs_rdy = use3 ? ready3 : ready;
        obs_lat = k;
        req = req & ~obs_rdy;
        break;
      end
    end
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdout = '0;
  endtask

  task automatic test_reset;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (ready !== 4'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0000", ready); end
    n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL rst_dout got %h want 0", dout); end
    n_cmp++; if ({cs, clken, mwrite, be, address, wdata} !== '0) begin n_bad++; $display("FAIL rst_bus got %b%b%b %b %h %h want all 0", cs, clken, mwrite, be, address, wdata); end
    n_cmp++; if (gidx !== 2'd0) begin n_bad++; $display("FAIL rst_gidx got %0d want 0", gidx); end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    @(negedge clk);
    addr[0*AW +: AW] = 20'h00ABC;
    wr = 4'b0000;
    req = 4'b0001;
    sb.push_back('{0, 1'b0, 20'h00ABC, 16'h1234});
    wait_done(0, 0, 2, 16'h1234);
    e = sb.pop_front();
    mdout[e.ch*DW +: DW] = e.r;
    n_cmp++; if (obs_iss !== 1) begin n_bad++; $display("FAIL rd_issue_cycle got %0d want 1", obs_iss); end
    n_cmp++; if (obs_addr !== e.a) begin n_bad++; $display("FAIL rd_addr got %h want %h", obs_addr, e.a); end
    n_cmp++; if (obs_w !== 1'b0) begin n_bad++; $display("FAIL rd_write got %b want 0", obs_w); end
    n_cmp++; if (obs_rdy !== (4'b0001 << e.ch)) begin n_bad++; $display("FAIL rd_ready got %b want %b", obs_rdy, 4'b0001 << e.ch); end
    n_cmp++; if (obs_lat !== 3) begin n_bad++; $display("FAIL rd_latency got %0d want 3", obs_lat); end
    n_cmp++; if (dout !== mdout) begin n_bad++; $display("FAIL rd_dout got %h want %h", dout, mdout); end
  endtask

  task automatic test_write;
    @(negedge clk);
    addr[2*AW +: AW] = 20'hFFFFF;
    din[2*DW +: DW] = 16'h0FF0;
    wr = 4'b0100;
    req = 4'b0100;
    sb.push_back('{2, 1'b1, 20'hFFFFF, 16'h0});
    wait_done(0, 1, 0, 16'h0);
    e = sb.pop_front();
    wr = 4'b0000;
    n_cmp++; if (obs_w !== 1'b1) begin n_bad++; $display("FAIL wr_write got %b want 1", obs_w); end
    n_cmp++; if (obs_wd !== 16'h0FF0) begin n_bad++; $display("FAIL wr_wdata got %h want 0ff0", obs_wd); end
    n_cmp++; if (obs_be !== 2'b11) begin n_bad++; $display("FAIL wr_be got %b want 11", obs_be); end
    n_cmp++; if (obs_addr !== e.a) begin n_bad++; $display("FAIL wr_addr got %h want %h", obs_addr, e.a); end
    n_cmp++; if (obs_rdy !== 4'b0100) begin n_bad++; $display("FAIL wr_ready got %b want 0100", obs_rdy); end
    n_cmp++; if (obs_lat !== 2) begin n_bad++; $display("FAIL wr_latency got %0d want 2", obs_lat); end
    n_cmp++; if (dout !== mdout) begin n_bad++; $display("FAIL wr_dout got %h want %h", dout, mdout); end
  endtask

  task automatic test_round_robin;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    pulse_reset();
    wr = 4'b1010;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = 20'h00100 + 20'(i);
    foreach (order[j]) sb.push_back('{order[j], wr[order[j]], 20'h00100 + 20'(order[j]), 16'hA5A5});
    req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      wait_done(0, 0, 2, 16'hA5A5);
      e = sb.pop_front();
      if (!e.w) mdout[e.ch*DW +: DW] = e.r;
      n_cmp++; if (obs_g !== 2'(e.ch)) begin n_bad++; $display("FAIL rr_grant[%0d] got %0d want %0d", j, obs_g, e.ch); end
      n_cmp++; if (obs_rdy !== (4'b0001 << e.ch)) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", j, obs_rdy, 4'b0001 << e.ch); end
      n_cmp++; if (obs_lat !== (e.w ? 2 : 3)) begin n_bad++; $display("FAIL rr_latency[%0d] got %0d want %0d", j, obs_lat, e.w ? 2 : 3); end
      n_cmp++; if (obs_addr !== e.a) begin n_bad++; $display("FAIL rr_addr[%0d] got %h want %h", j, obs_addr, e.a); end
      if (j < 5) begin
        @(negedge clk);
        req = req | obs_rdy;
      end
    end
    req = 4'b0000;
    wr = 4'b0000;
    n_cmp++; if (dout !== mdout) begin n_bad++; $display("FAIL rr_dout got %h want %h", dout, mdout); end
  endtask

  task automatic test_halt;
    @(negedge clk);
    addr[0*AW +: AW] = 20'h00011;
    addr[1*AW +: AW] = 20'h00022;
    halt = 4'b0001;
    req = 4'b0011;
    sb.push_back('{1, 1'b0, 20'h00022, 16'h2222});
    wait_done(0, 0, 2, 16'h2222);
    e = sb.pop_front();
    mdout[e.ch*DW +: DW] = e.r;
    n_cmp++; if (obs_g !== 2'(e.ch)) begin n_bad++; $display("FAIL halt_grant got %0d want %0d", obs_g, e.ch); end
    n_cmp++; if (obs_rdy !== 4'b0010) begin n_bad++; $display("FAIL halt_ready got %b want 0010", obs_rdy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL halt_blocked busy got %b want 0", busy); end
    halt = 4'b0000;
    sb.push_back('{0, 1'b0, 20'h00011, 16'h3333});
    wait_done(0, 0, 2, 16'h3333);
    e = sb.pop_front();
    mdout[e.ch*DW +: DW] = e.r;
    n_cmp++; if (obs_g !== 2'(e.ch)) begin n_bad++; $display("FAIL unhalt_grant got %0d want %0d", obs_g, e.ch); end
    n_cmp++; if (obs_addr !== e.a) begin n_bad++; $display("FAIL unhalt_addr got %h want %h", obs_addr, e.a); end
    n_cmp++; if (dout !== mdout) begin n_bad++; $display("FAIL unhalt_dout got %h want %h", dout, mdout); end
  endtask

  task automatic test_abort;
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      addr[3*AW +: AW] = 20'h33333;
      addr[1*AW +: AW] = 20'h11111;
      req = 4'b1000;
      @(negedge clk);
      req = 4'b0000;
      @(negedge clk);
      n_cmp++; if ({cs, clken} !== 2'b01) begin n_bad++; $display("FAIL abort%0d_wait got cs/clken %b%b want 01", m, cs, clken); end
      if (m == 0) init = 1'b1; else reset = 1'b1;
      @(negedge clk);
      init = 1'b0;
      reset = 1'b0;
      mdout = '0;
      n_cmp++; if ({ready, busy} !== 5'b0) begin n_bad++; $display("FAIL abort%0d_ready_busy got %b %b want 0000 0", m, ready, busy); end
      n_cmp++; if ({cs, clken, mwrite, be, address, wdata} !== '0) begin n_bad++; $display("FAIL abort%0d_bus got %b%b%b %b %h %h want all 0", m, cs, clken, mwrite, be, address, wdata); end
      n_cmp++; if (dout !== mdout) begin n_bad++; $display("FAIL abort%0d_dout got %h want %h", m, dout, mdout); end
      n_cmp++; if (gidx !== 2'd0) begin n_bad++; $display("FAIL abort%0d_gidx got %0d want 0", m, gidx); end
      req = 4'b1010;
      sb.push_back('{1, 1'b0, 20'h11111, 16'h4444 + 16'(m)});
      wait_done(0, 0, 2, 16'h4444 + 16'(m));
      req = 4'b0000;
      e = sb.pop_front();
      mdout[e.ch*DW +: DW] = e.r;
      n_cmp++; if (obs_g !== 2'(e.ch)) begin n_bad++; $display("FAIL abort%0d_next_grant got %0d want %0d", m, obs_g, e.ch); end
      n_cmp++; if (obs_lat !== 3) begin n_bad++; $display("FAIL abort%0d_next_latency got %0d want 3", m, obs_lat); end
      n_cmp++; if (dout !== mdout) begin n_bad++; $display("FAIL abort%0d_next_dout got %h want %h", m, dout, mdout); end
    end
  endtask

  task automatic test_latency;
    logic [N*DW-1:0] m3;
    pulse_reset();
    m3 = '0;
    addr[3*AW +: AW] = 20'h5A5A5;
    req = 4'b1000;
    sb.push_back('{3, 1'b0, 20'h5A5A5, 16'hBEEF});
    wait_done(1, 1, 4, 16'hBEEF);
    req = 4'b0000;
    e = sb.pop_front();
    m3[e.ch*DW +: DW] = e.r;
    n_cmp++; if (obs_iss !== 1) begin n_bad++; $display("FAIL lat3_issue_cycle got %0d want 1", obs_iss); end
    n_cmp++; if (obs_addr !== e.a) begin n_bad++; $display("FAIL lat3_addr got %h want %h", obs_addr, e.a); end
    n_cmp++; if (obs_lat !== 5) begin n_bad++; $display("FAIL lat3_latency got %0d want 5", obs_lat); end
    n_cmp++; if (obs_rdy !== 4'b1000) begin n_bad++; $display("FAIL lat3_ready got %b want 1000", obs_rdy); end
    n_cmp++; if (dout3 !== m3) begin n_bad++; $display("FAIL lat3_dout got %h want %h", dout3, m3); end
  endtask

  initial begin
    reset = 1'b1;
    init = 1'b0;
    req = '0;
    wr = '0;
    halt = '0;
    addr = '0;
    din = '0;
    rdata = '0;
    mdout = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_halt();
    test_abort();
    test_latency();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
